// File: rtl/pad_cfg_pkg.sv
// pad_cfg_pkg: shared sizes, register offsets, CTRL bit positions and
// sequencer states for the pad configuration controller.
package pad_cfg_pkg;

  localparam int NUM_PADS = 48;
  localparam int CFG_W    = 6;
  localparam int MUX_W    = 2;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int SETTLE_W = 4;

  // PADn register: cfg in the low bits, mux select starting at bit 8
  localparam int MUX_LSB  = 8;

  localparam logic [ADDR_W-1:0] PAD_BASE   = 12'h000;
  localparam logic [ADDR_W-1:0] CTRL_OFF   = 12'h0C0;
  localparam logic [ADDR_W-1:0] SETTLE_OFF = 12'h0C4;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_BUSY_BIT   = 1;
  localparam int CTRL_LOCK_BIT   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SETTLE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pad_cfg_if.sv
// pad_cfg_if: APB slave signal group for the pad configuration controller.
interface pad_cfg_if;
  import pad_cfg_pkg::*;

  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pwrite;
  logic              psel;
  logic              penable;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/pad_cfg_seq.sv
// pad_cfg_seq: walks the pad bank one pad at a time after a commit, with
// a programmable number of idle settle cycles after each pad update.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | no commit in progress; waits for start
//   APPLY  | apply_en high: live[apply_idx] takes shadow[apply_idx]
//   SETTLE | down-counting cnt idle cycles before the next pad
module pad_cfg_seq #(
  parameter  int NUM_PADS = pad_cfg_pkg::NUM_PADS,
  localparam int IDX_W    = $clog2(NUM_PADS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [pad_cfg_pkg::SETTLE_W-1:0] settle,
  output logic                             apply_en,
  output logic [IDX_W-1:0]                 apply_idx,
  output logic                             busy,
  output logic                             done
);
  import pad_cfg_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PADS - 1);

  seq_state_t          state;
  logic [SETTLE_W-1:0] s_lat;
  logic [SETTLE_W-1:0] cnt;
  logic                last;

  assign last = (apply_idx == LAST_IDX);

  // Sequencer: state, pad index, settle down-counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      apply_idx <= '0;
      cnt       <= '0;
      s_lat     <= '0;
      apply_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= APPLY;
            apply_idx <= '0;
            s_lat     <= settle;
            apply_en  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        APPLY: begin
          if (s_lat != '0) begin
            state    <= SETTLE;
            cnt      <= s_lat - SETTLE_W'(1);
            apply_en <= 1'b0;
          end else if (last) begin
            state    <= IDLE;
            apply_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            apply_idx <= apply_idx + IDX_W'(1);
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - SETTLE_W'(1);
          end else if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= APPLY;
            apply_idx <= apply_idx + IDX_W'(1);
            apply_en  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          apply_en <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pad_cfg_ctrl.sv
// pad_cfg_ctrl: APB register file holding shadow pad settings, and the live
// pad cfg/mux outputs that the sequencer loads one pad at a time on commit.
// Optional build macro PAD_CFG_LOCK_EN adds a sticky CTRL.LOCK bit that
// blocks PADn, SETTLE and COMMIT writes until reset.
module pad_cfg_ctrl #(
  parameter int NUM_PADS = pad_cfg_pkg::NUM_PADS,
  parameter int CFG_W    = pad_cfg_pkg::CFG_W,
  parameter int MUX_W    = pad_cfg_pkg::MUX_W
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  pad_cfg_if.slave                       apb,
  output logic [NUM_PADS-1:0][CFG_W-1:0] pad_cfg_o,
  output logic [NUM_PADS-1:0][MUX_W-1:0] pad_mux_o,
  output logic                           busy_o,
  output logic                           done_o
);
  import pad_cfg_pkg::*;

  localparam int IDX_W  = $clog2(NUM_PADS);
  localparam int WORD_W = ADDR_W - 2;

  logic [NUM_PADS-1:0][CFG_W-1:0] shadow_cfg;
  logic [NUM_PADS-1:0][MUX_W-1:0] shadow_mux;
  logic [SETTLE_W-1:0]            settle_val;
  logic                           lock;

  logic              access;
  logic              wr;
  logic              err;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] pad_word;
  logic [IDX_W-1:0]  pad_idx;
  logic              pad_hit;
  logic              ctrl_hit;
  logic              settle_hit;
  logic              commit;
  logic              start;
  logic [DATA_W-1:0] rdata;

  logic              apply_en;
  logic [IDX_W-1:0]  apply_idx;

  // Address bits [1:0] and the unmapped data bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{apb.pwdata[DATA_W-1:MUX_LSB+MUX_W],
                         apb.pwdata[MUX_LSB-1:CFG_W],
                         apb.paddr[1:0]};

  assign access     = apb.psel & apb.penable;
  assign wr         = access & apb.pwrite;
  assign word       = apb.paddr[ADDR_W-1:2];
  assign pad_word   = word - PAD_BASE[ADDR_W-1:2];
  assign pad_hit    = (pad_word < WORD_W'(NUM_PADS));
  assign pad_idx    = pad_word[IDX_W-1:0];
  assign ctrl_hit   = (word == CTRL_OFF[ADDR_W-1:2]);
  assign settle_hit = (word == SETTLE_OFF[ADDR_W-1:2]);
  assign commit     = apb.pwdata[CTRL_COMMIT_BIT];

  // Read mux and error decode; a rejected write must not touch any state.
  always_comb begin
    rdata = '0;
    err   = 1'b0;
    if (pad_hit) begin
      rdata[CFG_W-1:0]        = shadow_cfg[pad_idx];
      rdata[MUX_LSB +: MUX_W] = shadow_mux[pad_idx];
      err = apb.pwrite & (busy_o | lock);
    end else if (ctrl_hit) begin
      rdata[CTRL_BUSY_BIT] = busy_o;
      rdata[CTRL_LOCK_BIT] = lock;
      err = apb.pwrite & commit & (busy_o | lock);
    end else if (settle_hit) begin
      rdata[SETTLE_W-1:0] = settle_val;
      err = apb.pwrite & (busy_o | lock);
    end else begin
      err = 1'b1;
    end
  end

  assign apb.prdata  = access ? rdata : '0;
  assign apb.pslverr = access & err;
  assign apb.pready  = 1'b1;

  assign start = wr & ctrl_hit & commit & ~err;

  // Shadow registers and SETTLE, written by accepted APB writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_cfg <= '0;
      shadow_mux <= '0;
      settle_val <= '0;
    end else if (wr && !err) begin
      if (pad_hit) begin
        shadow_cfg[pad_idx] <= apb.pwdata[CFG_W-1:0];
        shadow_mux[pad_idx] <= apb.pwdata[MUX_LSB +: MUX_W];
      end
      if (settle_hit) begin
        settle_val <= apb.pwdata[SETTLE_W-1:0];
      end
    end
  end

`ifdef PAD_CFG_LOCK_EN
  // Sticky lock: set by software, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock <= 1'b0;
    end else if (wr && !err && ctrl_hit && apb.pwdata[CTRL_LOCK_BIT]) begin
      lock <= 1'b1;
    end
  end
`else
  assign lock = 1'b0;
`endif

  // Live outputs: one pad copied from shadow per sequencer apply cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pad_cfg_o <= '0;
      pad_mux_o <= '0;
    end else if (apply_en) begin
      pad_cfg_o[apply_idx] <= shadow_cfg[apply_idx];
      pad_mux_o[apply_idx] <= shadow_mux[apply_idx];
    end
  end

  pad_cfg_seq #(
    .NUM_PADS (NUM_PADS)
  ) u_seq (
    .clk       (clk_i),
    .rst       (rst_i),
    .start     (start),
    .settle    (settle_val),
    .apply_en  (apply_en),
    .apply_idx (apply_idx),
    .busy      (busy_o),
    .done      (done_o)
  );

endmodule
